// File: rtl/accel_pkg.sv
// Shared definitions for the accelerometer conditioning path: processing FSM
// encoding and helpers used to size counters and the BCD clamp.
package accel_pkg;

    // Processing FSM states; one division is LOAD -> DIV -> STORE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_DIV     = 3'd2,
        ST_STORE   = 3'd3,
        ST_PUBLISH = 3'd4
    } state_e;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

    // Largest value displayable with the given number of BCD digits
    // (10^digits - 1); instantiating modules set BCD_MAX = bcd_max(DIGITS).
    function automatic int bcd_max(input int digits);
        int r;
        r = 1;
        for (int i = 0; i < digits; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/seq_udiv.sv
// Restoring unsigned divider: one quotient bit per cycle, DATA_W cycles per
// operation. done is high during the cycle whose closing edge writes the
// final quotient/remainder, so both are valid from the following cycle on.
module seq_udiv
    import accel_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CNT_W = clog2_min1(DATA_W + 1);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [DATA_W:0]   shifted_d;
    logic [DATA_W:0]   trial_d;

    // Shift the next dividend bit into the partial remainder and trial-subtract;
    // a clear top bit of the trial means the divisor fits.
    assign shifted_d = {rem_q, quo_q[DATA_W-1]};
    assign trial_d   = shifted_d - {1'b0, dvs_q};

    assign done      = (cnt_q == CNT_W'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    // Load operands on start, then resolve one quotient bit per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            if (!trial_d[DATA_W]) begin
                rem_q <= trial_d[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_q <= shifted_d[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/accel_axis_conditioner.sv
// N-axis conditioner: block-averages raw samples, then per axis produces a
// sign, a scaled saturated magnitude and BCD digits using one shared divider.
module accel_axis_conditioner
    import accel_pkg::*;
#(
    parameter int NUM_AXES  = 3,
    parameter int DATA_W    = 16,
    parameter int AVG_LOG2  = 2,
    parameter int SCALE_DIV = 10,
    parameter int OUT_W     = 8,
    parameter int DIGITS    = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         sample_valid,
    input  logic [NUM_AXES*DATA_W-1:0]   sample_data,
    input  logic                         freeze,
    output logic [NUM_AXES*OUT_W-1:0]    axis_mag,
    output logic [NUM_AXES-1:0]          axis_neg,
    output logic [NUM_AXES-1:0]          axis_sat,
    output logic [NUM_AXES*DIGITS*4-1:0] bcd,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam int ACC_W   = DATA_W + AVG_LOG2;
    localparam int CNT_W   = clog2_min1(2 ** AVG_LOG2);
    localparam int AX_W    = clog2_min1(NUM_AXES);
    localparam int DG_W    = clog2_min1(DIGITS);
    localparam int BCD_MAX = bcd_max(DIGITS);
    localparam int MAG_MAX = (2 ** OUT_W) - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((2 ** AVG_LOG2) - 1);
    localparam logic [AX_W-1:0]  AX_LAST  = AX_W'(NUM_AXES - 1);
    localparam logic [DG_W-1:0]  DG_LAST  = DG_W'(DIGITS - 1);

    // Accumulation path
    logic [CNT_W-1:0]         cnt_q;
    logic signed [ACC_W-1:0]  acc_q [NUM_AXES];
    logic signed [ACC_W-1:0]  sum_d [NUM_AXES];
    logic signed [DATA_W-1:0] avg_d [NUM_AXES];
    logic                     take_sample;
    logic                     block_done;
    logic                     overrun_q;

    // Processing path
    state_e                   state_q;
    logic [AX_W-1:0]          ax_q;
    logic [DG_W-1:0]          dig_q;
    logic signed [DATA_W-1:0] snap_q [NUM_AXES];
    logic [DATA_W-1:0]        abs_d  [NUM_AXES];
    logic [NUM_AXES-1:0]      neg_d;
    logic [DATA_W-1:0]        work_q;
    logic [NUM_AXES*OUT_W-1:0]    stage_mag_q;
    logic [NUM_AXES-1:0]          stage_sat_q;
    logic [NUM_AXES*DIGITS*4-1:0] stage_bcd_q;

    // Published outputs
    logic [NUM_AXES*OUT_W-1:0]    mag_q;
    logic [NUM_AXES-1:0]          neg_q;
    logic [NUM_AXES-1:0]          sat_q;
    logic [NUM_AXES*DIGITS*4-1:0] bcd_q;
    logic                         out_valid_q;

    // Divider interface
    logic              div_start;
    logic              div_done;
    logic [DATA_W-1:0] div_dividend;
    logic [DATA_W-1:0] div_divisor;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    logic              q_sat;
    logic [OUT_W-1:0]  q_mag;
    logic [DATA_W-1:0] q_bcd;
    int                digit_slot;

    assign take_sample = sample_valid && !freeze;
    assign block_done  = take_sample && (cnt_q == CNT_LAST);

    // Per-axis sum, floor-average and sign/magnitude of the snapshot.
    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
        logic signed [DATA_W-1:0] sample_s;
        assign sample_s   = sample_data[gi*DATA_W +: DATA_W];
        assign sum_d[gi]  = acc_q[gi] + ACC_W'(sample_s);
        assign avg_d[gi]  = DATA_W'(sum_d[gi] >>> AVG_LOG2);
        assign neg_d[gi]  = snap_q[gi][DATA_W-1];
        // Two's-complement negate: -2^(DATA_W-1) maps to 2^(DATA_W-1) unsigned.
        assign abs_d[gi]  = neg_d[gi] ? $unsigned(-snap_q[gi]) : $unsigned(snap_q[gi]);
    end

    // First division of an axis scales the magnitude; later ones peel digits.
    assign div_start    = (state_q == ST_LOAD);
    assign div_dividend = (dig_q == '0) ? abs_d[ax_q] : work_q;
    assign div_divisor  = (dig_q == '0) ? DATA_W'(SCALE_DIV) : DATA_W'(10);

    // Saturation drives the magnitude output; the digit path clamps the raw quotient.
    assign q_sat      = (quotient > DATA_W'(MAG_MAX));
    assign q_mag      = q_sat ? OUT_W'(MAG_MAX) : OUT_W'(quotient);
    assign q_bcd      = (quotient > DATA_W'(BCD_MAX)) ? DATA_W'(BCD_MAX) : quotient;
    assign digit_slot = int'(ax_q) * DIGITS + int'(dig_q);

    seq_udiv #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Accumulate unfrozen samples; clear at each block boundary and flag blocks dropped while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            overrun_q <= block_done && (state_q != ST_IDLE);
            if (take_sample) begin
                cnt_q <= block_done ? '0 : cnt_q + 1'b1;
                for (int i = 0; i < NUM_AXES; i++) begin
                    acc_q[i] <= block_done ? '0 : sum_d[i];
                end
            end
        end
    end

    // Sequence the shared divider over axes and digits, then publish everything at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            ax_q        <= '0;
            dig_q       <= '0;
            work_q      <= '0;
            stage_mag_q <= '0;
            stage_sat_q <= '0;
            stage_bcd_q <= '0;
            mag_q       <= '0;
            neg_q       <= '0;
            sat_q       <= '0;
            bcd_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_AXES; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (block_done) begin
                        for (int i = 0; i < NUM_AXES; i++) begin
                            snap_q[i] <= avg_d[i];
                        end
                        ax_q    <= '0;
                        dig_q   <= '0;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: state_q <= ST_DIV;
                ST_DIV: begin
                    if (div_done) begin
                        state_q <= ST_STORE;
                    end
                end
                ST_STORE: begin
                    if (dig_q == '0) begin
                        stage_mag_q[int'(ax_q)*OUT_W +: OUT_W] <= q_mag;
                        stage_sat_q[ax_q]                      <= q_sat;
                        work_q                                 <= q_bcd;
                        if (DIGITS == 1) begin
                            stage_bcd_q[digit_slot*4 +: 4] <= q_bcd[3:0];
                        end
                    end else begin
                        stage_bcd_q[(digit_slot-1)*4 +: 4] <= remainder[3:0];
                        work_q                             <= quotient;
                        if (dig_q == DG_LAST) begin
                            stage_bcd_q[digit_slot*4 +: 4] <= quotient[3:0];
                        end
                    end
                    if (dig_q != DG_LAST) begin
                        dig_q   <= dig_q + 1'b1;
                        state_q <= ST_LOAD;
                    end else if (ax_q != AX_LAST) begin
                        dig_q   <= '0;
                        ax_q    <= ax_q + 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        dig_q   <= '0;
                        state_q <= ST_PUBLISH;
                    end
                end
                ST_PUBLISH: begin
                    mag_q       <= stage_mag_q;
                    neg_q       <= neg_d;
                    sat_q       <= stage_sat_q;
                    bcd_q       <= stage_bcd_q;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign axis_mag  = mag_q;
    assign axis_neg  = neg_q;
    assign axis_sat  = sat_q;
    assign bcd       = bcd_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != ST_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_accel_axis_conditioner.sv
// Directed bench for accel_axis_conditioner: a vector table of 4-sample
// blocks with hand-computed results, plus sequences for overrun, freeze,
// mid-run reset and a non-default parameter set.
module tb_accel_axis_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        sample_valid;
    logic [47:0] sample_data;
    logic        freeze;
    logic [23:0] axis_mag;
    logic [2:0]  axis_neg;
    logic [2:0]  axis_sat;
    logic [23:0] bcd;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    logic        sample_valid6;
    logic [47:0] sample_data6;
    logic        freeze6;
    logic [23:0] axis_mag6;
    logic [2:0]  axis_neg6;
    logic [2:0]  axis_sat6;
    logic [35:0] bcd6;
    logic        out_valid6;
    logic        busy6;
    logic        overrun6;

    accel_axis_conditioner dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .freeze       (freeze),
        .axis_mag     (axis_mag),
        .axis_neg     (axis_neg),
        .axis_sat     (axis_sat),
        .bcd          (bcd),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    accel_axis_conditioner #(
        .NUM_AXES  (3),
        .DATA_W    (16),
        .AVG_LOG2  (0),
        .SCALE_DIV (1),
        .OUT_W     (8),
        .DIGITS    (3)
    ) dut6 (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid6),
        .sample_data  (sample_data6),
        .freeze       (freeze6),
        .axis_mag     (axis_mag6),
        .axis_neg     (axis_neg6),
        .axis_sat     (axis_sat6),
        .bcd          (bcd6),
        .out_valid    (out_valid6),
        .busy         (busy6),
        .overrun      (overrun6)
    );

    typedef struct {
        logic [3:0][47:0] s;
        logic [23:0]      mag;
        logic [2:0]       neg;
        logic [2:0]       sat;
        logic [23:0]      bcd;
    } vec_t;

    localparam int NVEC = 5;
    vec_t  vecs [NVEC];
    string vec_name [NVEC];

    int pass_cnt = 0;
    int total_cnt = 0;
    int valid_seen = 0;
    int overrun_seen = 0;

    always @(negedge clk) begin
        if (out_valid) valid_seen++;
        if (overrun) overrun_seen++;
    end

    function automatic logic [47:0] mk(input int x, input int y, input int z);
        logic [15:0] xs, ys, zs;
        xs = 16'(x);
        ys = 16'(y);
        zs = 16'(z);
        return {zs, ys, xs};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_vec(input int i, input string nm,
                           input logic [47:0] s0, input logic [47:0] s1,
                           input logic [47:0] s2, input logic [47:0] s3,
                           input logic [23:0] mag, input logic [2:0] neg,
                           input logic [2:0] sat, input logic [23:0] bcdv);
        vec_name[i]  = nm;
        vecs[i].s[0] = s0;
        vecs[i].s[1] = s1;
        vecs[i].s[2] = s2;
        vecs[i].s[3] = s3;
        vecs[i].mag  = mag;
        vecs[i].neg  = neg;
        vecs[i].sat  = sat;
        vecs[i].bcd  = bcdv;
    endtask

    task automatic strobe(input logic [47:0] d, input logic frz);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_data  = d;
        freeze       = frz;
    endtask

    task automatic release_bus();
        @(negedge clk);
        sample_valid = 1'b0;
        freeze       = 1'b0;
    endtask

    // Cycles counted from the first negedge after the last strobe's edge; bounded.
    task automatic wait_valid(input bit six, output int cycles);
        cycles = 0;
        while (!(six ? out_valid6 : out_valid) && cycles < 400) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic check_outputs(input int i, input int lat, input int exp_lat);
        $display("block %s: latency %0d mag %h neg %b sat %b bcd %h",
                 vec_name[i], lat, axis_mag, axis_neg, axis_sat, bcd);
        check({vec_name[i], "_latency"}, 64'(lat), 64'(exp_lat));
        check({vec_name[i], "_mag"}, 64'(axis_mag), 64'(vecs[i].mag));
        check({vec_name[i], "_neg"}, 64'(axis_neg), 64'(vecs[i].neg));
        check({vec_name[i], "_sat"}, 64'(axis_sat), 64'(vecs[i].sat));
        check({vec_name[i], "_bcd"}, 64'(bcd), 64'(vecs[i].bcd));
        check({vec_name[i], "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic run_block(input int i);
        int lat;
        for (int k = 0; k < 4; k++) strobe(vecs[i].s[k], 1'b0);
        release_bus();
        check({vec_name[i], "_busy_start"}, 64'(busy), 64'd1);
        wait_valid(1'b0, lat);
        check_outputs(i, lat, 109);
    endtask

    task automatic run6(input logic [47:0] d, input string nm, input logic [23:0] mag,
                        input logic [2:0] neg, input logic [2:0] sat, input logic [35:0] bcdv);
        int lat;
        @(negedge clk);
        sample_valid6 = 1'b1;
        sample_data6  = d;
        @(negedge clk);
        sample_valid6 = 1'b0;
        wait_valid(1'b1, lat);
        $display("p6 %s: latency %0d mag %h neg %b sat %b bcd %h",
                 nm, lat, axis_mag6, axis_neg6, axis_sat6, bcd6);
        check({nm, "_latency"}, 64'(lat), 64'd163);
        check({nm, "_mag"}, 64'(axis_mag6), 64'(mag));
        check({nm, "_neg"}, 64'(axis_neg6), 64'(neg));
        check({nm, "_sat"}, 64'(axis_sat6), 64'(sat));
        check({nm, "_bcd"}, 64'(bcd6), 64'(bcdv));
    endtask

    initial begin
        int lat;
        int v0, o0;

        set_vec(0, "basic",
                mk(100, -50, 1000), mk(100, -50, 1000), mk(104, -50, 1000), mk(100, -50, 1000),
                24'h64_05_0A, 3'b010, 3'b000, 24'h99_05_10);
        set_vec(1, "neg_full_scale",
                mk(-32768, 0, 0), mk(-32768, 0, 0), mk(-32768, 0, 0), mk(-32768, 0, 0),
                24'h00_00_FF, 3'b001, 3'b001, 24'h00_00_99);
        set_vec(2, "sat_edge",
                mk(-1, 2559, 2560), mk(0, 2559, 2560), mk(0, 2559, 2560), mk(0, 2559, 2560),
                24'hFF_FF_00, 3'b001, 3'b100, 24'h99_99_00);
        set_vec(3, "pos_full_scale",
                mk(32767, -9, 995), mk(32767, -10, 995), mk(32767, -11, 995), mk(32767, -10, 996),
                24'h63_01_FF, 3'b010, 3'b001, 24'h99_01_99);
        set_vec(4, "floor_round",
                mk(-60, 45, 0), mk(-59, 45, 0), mk(-59, 45, 0), mk(-59, 46, 0),
                24'h00_04_06, 3'b001, 3'b000, 24'h00_04_06);

        reset_n       = 1'b0;
        sample_valid  = 1'b0;
        sample_data   = '0;
        freeze        = 1'b0;
        sample_valid6 = 1'b0;
        sample_data6  = '0;
        freeze6       = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_mag", 64'(axis_mag), 64'd0);
        check("reset_bcd", 64'(bcd), 64'd0);
        check("reset_neg", 64'(axis_neg), 64'd0);
        check("reset_sat", 64'(axis_sat), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        check("reset_bcd6", 64'(bcd6), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven blocks.
        for (int i = 0; i < NVEC; i++) begin
            run_block(i);
            if (i == 0) begin
                @(negedge clk);
                check("valid_one_cycle", 64'(out_valid), 64'd0);
                check("outputs_hold", 64'(axis_mag), 64'(vecs[0].mag));
            end
            repeat (3) @(negedge clk);
        end

        // Second block arrives back-to-back while busy: dropped, one overrun.
        o0 = overrun_seen;
        for (int k = 0; k < 4; k++) strobe(vecs[0].s[k], 1'b0);
        for (int k = 0; k < 4; k++) strobe(mk(2000, 2000, 2000), 1'b0);
        release_bus();
        wait_valid(1'b0, lat);
        check_outputs(0, lat, 105);
        repeat (5) @(negedge clk);
        check("overrun_pulses", 64'(overrun_seen - o0), 64'd1);
        run_block(3);
        repeat (3) @(negedge clk);

        // Frozen strobes are ignored entirely.
        v0 = valid_seen;
        for (int k = 0; k < 3; k++) strobe(mk(30000, -30000, 30000), 1'b1);
        for (int k = 0; k < 4; k++) strobe(vecs[4].s[k], 1'b0);
        release_bus();
        wait_valid(1'b0, lat);
        check_outputs(4, lat, 109);
        repeat (150) @(negedge clk);
        check("freeze_valid_count", 64'(valid_seen - v0), 64'd1);

        // Asynchronous reset in the middle of a division.
        for (int k = 0; k < 4; k++) strobe(vecs[2].s[k], 1'b0);
        release_bus();
        repeat (10) @(negedge clk);
        v0 = valid_seen;
        #2 reset_n = 1'b0;
        #1;
        $display("reset mid-run: busy %b mag %h bcd %h", busy, axis_mag, bcd);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mag", 64'(axis_mag), 64'd0);
        check("abort_neg", 64'(axis_neg), 64'd0);
        check("abort_sat", 64'(axis_sat), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (150) @(negedge clk);
        check("abort_no_valid", 64'(valid_seen - v0), 64'd0);
        run_block(1);

        // No averaging, unit scale, three digits.
        run6(mk(-7, 300, 1234), "p6_first", 24'hFF_FF_07, 3'b001, 3'b110, 36'h999_300_007);
        run6(mk(5, 0, 250), "p6_second", 24'hFA_00_05, 3'b000, 3'b000, 36'h250_000_005);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
